// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and registers the
// fetched word into decode, with stall, branch redirect and a one-entry skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [3:0]  IF_ins_type,
  output logic [3:0]  IF_ins_number,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [3:0]  type_q, type_d;
  logic [3:0]  num_q, num_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] pc_plus4;

  // Opcode class of an instruction word, keyed on word[31:26].
  function automatic logic [3:0] decode(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (w == 32'h0)                         decode = 4'd0;
    else if (op == 6'h00)                   decode = 4'd1;
    else if (op[5:3] == 3'b001)             decode = 4'd2;
    else if (op == 6'h23)                   decode = 4'd3;
    else if (op == 6'h2B)                   decode = 4'd4;
    else if (op == 6'h04 || op == 6'h05)    decode = 4'd5;
    else if (op == 6'h02 || op == 6'h03)    decode = 4'd6;
    else                                    decode = 4'd0;
  endfunction

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    type_d      = type_q;
    num_d       = num_q;
    skid_inst_d = skid_inst_q;
    skid_pc4_d  = skid_pc4_q;

    if (branch_taken) begin
      // Redirect wins over everything; any word acked this cycle is dropped.
      pc_d        = {branch_target[31:2], 2'b00};
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      type_d      = 4'd0;
      skid_inst_d = 32'h0;
      skid_pc4_d  = 32'h0;
      state_d     = StFetch;
    end else if (stall) begin
      if (state_q == StFetch && imem_ack) begin
        skid_inst_d = imem_rdata;
        skid_pc4_d  = pc_plus4;
        state_d     = StHold;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (imem_ack) begin
            inst_d  = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            type_d  = decode(imem_rdata);
            num_d   = num_q + 4'd1;
            pc_d    = pc_plus4;
          end else begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            type_d  = 4'd0;
          end
        end
        StHold: begin
          inst_d  = skid_inst_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          type_d  = decode(skid_inst_q);
          num_d   = num_q + 4'd1;
          pc_d    = pc_plus4;
          state_d = StFetch;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      type_q      <= 4'd0;
      num_q       <= 4'd0;
      skid_inst_q <= 32'h0;
      skid_pc4_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      type_q      <= type_d;
      num_q       <= num_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
    end
  end

  assign imem_req      = (state_q == StFetch);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign if_inst       = inst_q;
  assign if_pc4        = pc4_q;
  assign if_valid      = valid_q;
  assign IF_ins_type   = type_q;
  assign IF_ins_number = num_q;

endmodule
